keypad_scanner: RTL and testbench

- Scans a 4x4 matrix keypad (Pmod KYPD layout) by driving one column low at a time and sampling the active-low rows.
- Debounces the sampled rows and emits one event per clean key press as a 4-bit hex code.
- Accumulates the last four key codes into a 16-bit entry word that feeds the four-digit seven-segment controller's 16-bit data input.
- Input-side counterpart of the multiplexed display: user hex entry instead of switches.

---
 rtl/keypad_scanner.sv | 154 +++++++++++++++
 tb/tb_keypad_scanner.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row synchronizer, per-frame key
// classification, frame-level debounce and a 16-bit hex entry shift register.
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 100000,
  parameter int DEBOUNCE_FRAMES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] entry
);

  localparam int CW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int SW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SCAN_CYCLES - 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(DEBOUNCE_FRAMES);

  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_t;
  typedef enum logic [1:0] {CLS_NONE = 2'd0, CLS_ONE = 2'd1, CLS_MULTI = 2'd2} cls_t;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  4'hF: k = 4'hD;
    endcase
    return k;
  endfunction

  function automatic logic [1:0] sat_count(input logic [1:0] cur, input logic [2:0] add);
    logic [2:0] sum;
    sum = {1'b0, cur} + add;
    return (sum >= 3'd2) ? 2'd2 : sum[1:0];
  endfunction

  logic [3:0]    row_s1, row_s2;
  logic [CW-1:0] cnt;
  logic [1:0]    colidx;
  logic          sample;
  logic          frame_end;
  logic [1:0]    pcount, pcount_nx;
  logic [3:0]    cand, cand_nx;
  logic [2:0]    hits;
  logic [1:0]    first_row;
  cls_t          cls_type, last_type;
  logic [3:0]    cls_key, last_key;
  logic [SW-1:0] stab, stab_nx;
  state_t        state, state_nx;
  logic          accept;

  // Row synchronizer (data path, not reset)
  always_ff @(posedge clk) begin
    row_s1 <= row;
    row_s2 <= row_s1;
  end

  assign sample = (cnt == CNT_MAX);

  // Column sample: count pressed rows and locate the first one in row order
  always_comb begin
    hits      = '0;
    first_row = '0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_s2[r]) begin
        hits      = hits + 3'd1;
        first_row = 2'(r);
      end
    end
    pcount_nx = sat_count(pcount, hits);
    cand_nx   = cand;
    if (pcount == 2'd0 && hits != 3'd0) cand_nx = key_map(first_row, colidx);
  end

  // Frame classification and stability count
  always_comb begin
    case (pcount)
      2'd0:    cls_type = CLS_NONE;
      2'd1:    cls_type = CLS_ONE;
      default: cls_type = CLS_MULTI;
    endcase
    cls_key = (pcount == 2'd1) ? cand : 4'h0;
    if (cls_type == last_type && cls_key == last_key)
      stab_nx = (stab == STAB_MAX) ? stab : stab + 1'b1;
    else
      stab_nx = SW'(1);
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    if (frame_end) begin
      case (state)
        IDLE: if (cls_type == CLS_ONE && stab_nx == STAB_MAX) begin
          accept   = 1'b1;
          state_nx = HELD;
        end
        HELD: if (cls_type == CLS_NONE && stab_nx == STAB_MAX) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt       <= '0;
      colidx    <= 2'd0;
      col       <= 4'b1110;
      frame_end <= 1'b0;
      pcount    <= 2'd0;
      cand      <= 4'h0;
      last_type <= CLS_NONE;
      last_key  <= 4'h0;
      stab      <= '0;
      state     <= IDLE;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      entry     <= 16'h0000;
    end else begin
      if (sample) begin
        cnt    <= '0;
        colidx <= colidx + 2'd1;
        col    <= {col[2:0], col[3]};
      end else begin
        cnt <= cnt + 1'b1;
      end
      frame_end <= sample && (colidx == 2'd3);
      if (frame_end) begin
        pcount    <= 2'd0;
        cand      <= 4'h0;
        last_type <= cls_type;
        last_key  <= cls_key;
        stab      <= stab_nx;
      end else if (sample) begin
        pcount <= pcount_nx;
        cand   <= cand_nx;
      end
      state     <= state_nx;
      key_valid <= accept;
      if (accept) begin
        key_code <= cls_key;
        entry    <= {entry[11:0], cls_key};
      end
    end
  end

  assign key_held = (state == HELD);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a matrix keypad model drives rows from col, and a
// scoreboard queue holds the key events (code, entry) each scenario should produce.
module tb_keypad_scanner;

  localparam int SC = 4;
  localparam int DF = 2;
  localparam int FRAME = 4 * SC;
  localparam logic [3:0] KMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                       4'h4, 4'h5, 4'h6, 4'hB,
                                       4'h7, 4'h8, 4'h9, 4'hC,
                                       4'h0, 4'hF, 4'hE, 4'hD};

  typedef struct {
    logic [3:0]  code;
    logic [15:0] ent;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] entry;

  logic [15:0] keys;
  logic [15:0] exp_entry;
  exp_t        q[$];
  exp_t        e;
  int          n_chk = 0;
  int          n_pass = 0;

  keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_FRAMES(DF)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held),
    .entry    (entry)
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed key pulls its row low while its column is driven
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] key_bit(input logic [3:0] k);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) if (KMAP[i] == k) m[i] = 1'b1;
    return m;
  endfunction

  task automatic expect_key(input logic [3:0] k);
    exp_entry = {exp_entry[11:0], k};
    q.push_back('{code: k, ent: exp_entry});
  endtask

  task automatic run_frames(input int n);
    repeat (n * FRAME) @(negedge clk);
  endtask

  task automatic held_is(input string tag, input logic v);
    chk(tag, {15'b0, key_held}, {15'b0, v});
  endtask

  // Press k alone, check exact acceptance frame, then release fully
  task automatic tap(input logic [3:0] k);
    expect_key(k);
    keys = key_bit(k);
    run_frames(2);
    held_is("tap_not_yet", 1'b0);
    run_frames(1);
    held_is("tap_held", 1'b1);
    keys = '0;
    run_frames(2);
    held_is("tap_still_held", 1'b1);
    run_frames(1);
    held_is("tap_released", 1'b0);
  endtask

  // Scoreboard: every key_valid pulse must match the next queued event
  always @(negedge clk) begin
    if (key_valid) begin
      if (q.size() == 0) begin
        chk("spurious_valid", {12'b0, key_code}, 16'hFFFF);
      end else begin
        e = q.pop_front();
        chk("key_code", {12'b0, key_code}, {12'b0, e.code});
        chk("entry", entry, e.ent);
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    keys      = '0;
    exp_entry = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_col", {12'b0, col}, 16'h000E);
    chk("rst_code", {12'b0, key_code}, 16'h0000);
    chk("rst_valid", {15'b0, key_valid}, 16'h0000);
    chk("rst_held", {15'b0, key_held}, 16'h0000);
    chk("rst_entry", entry, 16'h0000);
    reset_n = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      chk("col_seq", {12'b0, col}, {12'b0, ~(4'b0001 << ((i / SC) % 4))});
      @(negedge clk);
    end

    // Single press of 5 held four frames, then A, 1, 2, 3
    expect_key(4'h5);
    keys = key_bit(4'h5);
    run_frames(2);
    held_is("p5_not_yet", 1'b0);
    run_frames(1);
    held_is("p5_held", 1'b1);
    chk("p5_entry", entry, 16'h0005);
    run_frames(1);
    keys = '0;
    run_frames(2);
    held_is("p5_still_held", 1'b1);
    run_frames(1);
    held_is("p5_released", 1'b0);
    tap(4'hA);
    chk("entry_5A", entry, 16'h005A);
    tap(4'h1);
    tap(4'h2);
    tap(4'h3);
    chk("entry_A123", entry, 16'hA123);

    // Bounce on 9: alternating frames never settle
    for (int f = 0; f < 10; f++) begin
      keys = (f % 2 == 0) ? key_bit(4'h9) : 16'h0;
      run_frames(1);
    end
    held_is("bounce_no_hold", 1'b0);
    tap(4'h9);
    chk("bounce_code", {12'b0, key_code}, 16'h0009);

    // Ghosting: 1 and 6 together are rejected, 1 alone is accepted
    keys = key_bit(4'h1) | key_bit(4'h6);
    run_frames(5);
    held_is("ghost_no_hold", 1'b0);
    tap(4'h1);

    // Long hold of D, then slide to E without release
    expect_key(4'hD);
    keys = key_bit(4'hD);
    run_frames(20);
    held_is("d_held", 1'b1);
    keys = key_bit(4'hE);
    run_frames(4);
    held_is("e_slide_held", 1'b1);
    chk("e_slide_code", {12'b0, key_code}, 16'h000D);
    keys = '0;
    run_frames(3);
    held_is("d_released", 1'b0);
    tap(4'hE);
    chk("e_code", {12'b0, key_code}, 16'h000E);

    // Reset while 7 is mid-debounce
    keys = key_bit(4'h7);
    run_frames(1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n   = 1'b1;
    exp_entry = 16'h0000;
    chk("mid_rst_entry", entry, 16'h0000);
    chk("mid_rst_code", {12'b0, key_code}, 16'h0000);
    chk("mid_rst_col", {12'b0, col}, 16'h000E);
    expect_key(4'h7);
    run_frames(2);
    held_is("p7_not_yet", 1'b0);
    run_frames(1);
    held_is("p7_held", 1'b1);
    chk("p7_entry", entry, 16'h0007);
    keys = '0;
    run_frames(3);
    held_is("p7_released", 1'b0);

    chk("queue_drained", 16'(q.size()), 16'h0000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
